// File: rtl/vga_pkg.sv
// vga_pkg: 800x600 timing constants, host FSM encoding and frame-buffer parking address
package vga_pkg;
    localparam int H_SYNC = 128;
    localparam int H_BP = 88;
    localparam int V_SYNC = 4;
    localparam int V_BP = 23;
    localparam int HSTART = H_SYNC + H_BP;
    localparam int VSTART = V_SYNC + V_BP;
    localparam logic [10:0] PARK_ADDR_DFLT = 11'd17;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} host_st_t;
endpackage

// File: rtl/vga_window_decode.sv
// vga_window_decode: registered flag marking the guarded display window around the visible image
module vga_window_decode #(
    parameter int _X = 128,
    parameter int _Y = 128,
    parameter int _XOFF = 0,
    parameter int _YOFF = 0,
    parameter int HSTART = vga_pkg::HSTART,
    parameter int VSTART = vga_pkg::VSTART,
    parameter int GUARD = 3
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [10:0] qC1,
    input  logic [9:0]  qC2,
    output logic        disp_win_r
);
    localparam logic [11:0] V_LO = 12'(VSTART + _YOFF);
    localparam logic [11:0] V_HI = 12'(VSTART + _YOFF + _Y);
    localparam logic [11:0] H_LO = 12'(HSTART + _XOFF - GUARD);
    localparam logic [11:0] H_HI = 12'(HSTART + _XOFF + _X + GUARD);
    logic [11:0] h, v;
    assign h = {1'b0, qC1};
    assign v = {2'b0, qC2};
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) disp_win_r <= 1'b0;
        else disp_win_r <= v > V_LO && v <= V_HI && h > H_LO && h <= H_HI;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port frame-buffer RAM between the VGA fetcher and a host port
module vga_fb_arbiter #(
    parameter int _X = 128,
    parameter int _Y = 128,
    parameter int _XOFF = 0,
    parameter int _YOFF = 0,
    parameter int HSTART = vga_pkg::HSTART,
    parameter int VSTART = vga_pkg::VSTART,
    parameter int GUARD = 3,
    parameter logic [10:0] PARK_ADDR = vga_pkg::PARK_ADDR_DFLT
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [10:0] qC1,
    input  logic [9:0]  qC2,
    input  logic [10:0] disp_addr,
    output logic [7:0]  disp_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [10:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy
);
    vga_pkg::host_st_t st;
    logic        disp_win_r;
    logic [10:0] a_q;
    logic        we_q;
    logic [7:0]  wd_q;

    vga_window_decode #(
        ._X(_X), ._Y(_Y), ._XOFF(_XOFF), ._YOFF(_YOFF),
        .HSTART(HSTART), .VSTART(VSTART), .GUARD(GUARD)
    ) u_win (
        .CLK(CLK), .RSTn(RSTn), .qC1(qC1), .qC2(qC2), .disp_win_r(disp_win_r)
    );

    // display always wins the port; the guard band keeps host cycles clear of the image span
    always_comb begin
        ram_addr = disp_win_r ? disp_addr : st == vga_pkg::ST_ISSUE ? a_q : PARK_ADDR;
        ram_we = !disp_win_r && st == vga_pkg::ST_ISSUE && we_q;
        ram_wdata = wd_q;
        disp_data = ram_rdata;
    end

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            st <= vga_pkg::ST_IDLE;
            host_ack <= 1'b0;
            host_rdata <= 8'h00;
            busy <= 1'b0;
            a_q <= PARK_ADDR;
            we_q <= 1'b0;
            wd_q <= 8'h00;
        end else begin
            host_ack <= 1'b0;
            case (st)
                vga_pkg::ST_IDLE:
                    if (host_req && !disp_win_r && !host_ack) begin
                        st <= vga_pkg::ST_ISSUE;
                        busy <= 1'b1;
                        a_q <= host_addr;
                        we_q <= host_we;
                        wd_q <= host_wdata;
                    end
                vga_pkg::ST_ISSUE: begin
                    st <= we_q ? vga_pkg::ST_ACK : vga_pkg::ST_WAIT;
                    host_ack <= we_q;
                end
                vga_pkg::ST_WAIT: begin
                    host_rdata <= ram_rdata;
                    st <= vga_pkg::ST_ACK;
                    host_ack <= 1'b1;
                end
                vga_pkg::ST_ACK: begin
                    st <= vga_pkg::ST_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized checks of the frame-buffer arbiter against a behavioural memory/window model
module tb_vga_fb_arbiter;
    localparam int XW = 128, YH = 128, HS = 216, VS = 27, G = 3;
    logic CLK = 1'b0, RSTn = 1'b1;
    logic [10:0] qC1 = '0;
    logic [9:0] qC2 = '0;
    logic [10:0] disp_addr = '0;
    logic [7:0] disp_data;
    logic host_req = 1'b0, host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic host_ack, busy, ram_we;
    logic [7:0] host_rdata, ram_wdata, ram_rdata;
    logic [10:0] ram_addr;
    logic [7:0] mem [2048];
    logic [7:0] ref_mem [2048];
    int n_cmp = 0, n_fail = 0, we_cnt = 0;
    logic [10:0] last_wa;
    logic [7:0] last_wd;

    vga_fb_arbiter dut (
        .CLK(CLK), .RSTn(RSTn), .qC1(qC1), .qC2(qC2), .disp_addr(disp_addr), .disp_data(disp_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt <= we_cnt + 1;
            last_wa <= ram_addr;
            last_wd <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    function automatic bit win(int q1, int q2);
        return q2 > VS && q2 <= VS + YH && q1 > HS - G && q1 <= HS + XW + G;
    endfunction

    // first qC1 at which a request raised at req_at reaches ISSUE
    function automatic int exp_issue(int q2, int req_at);
        int c = req_at;
        while (win(c - 1, q2)) c++;
        return c + 1;
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic host_txn(input bit we, input logic [10:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; lat = 0;
        do begin
            step();
            lat++;
        end while (host_ack !== 1'b1 && lat < 20);
        rd = host_rdata;
        if (we && host_ack === 1'b1) ref_mem[a] = d;
        host_req = 1'b0;
        step();
    endtask

    task automatic run_line(input int q2, input int c0, input int c1, input int req_at,
                            input bit we, input logic [10:0] a, input logic [7:0] d,
                            output int issue_q1, output int ack_q1, output logic [7:0] rd,
                            output int addr_err, output int data_err, output int win_cyc);
        bit pv_open = 0, acked = 0;
        logic [10:0] pv_addr = '0;
        issue_q1 = -1; ack_q1 = -1; rd = '0; addr_err = 0; data_err = 0; win_cyc = 0;
        qC2 = 10'(q2); qC1 = 11'(c0); host_req = 1'b0; host_we = we; host_addr = a; host_wdata = d;
        disp_addr = 11'($urandom);
        step();
        for (int c = c0 + 1; c <= c1; c++) begin
            qC1 = 11'(c);
            disp_addr = 11'($urandom);
            if (c == req_at) host_req = 1'b1;
            if (acked) host_req = 1'b0;
            #1;
            if (pv_open && disp_data !== ref_mem[pv_addr]) data_err++;
            if (win(c - 1, q2)) begin
                win_cyc++;
                if (ram_addr !== disp_addr || ram_we !== 1'b0) addr_err++;
            end
            if (busy === 1'b1 && issue_q1 < 0) issue_q1 = c;
            if (host_ack === 1'b1 && ack_q1 < 0) begin
                ack_q1 = c; rd = host_rdata; acked = 1;
                if (we) ref_mem[a] = d;
            end
            pv_open = win(c - 1, q2);
            pv_addr = disp_addr;
            step();
        end
        host_req = 1'b0;
    endtask

    task automatic test_reset;
        int stuck = 0, bad_mux = 0, lat = 0;
        #2 RSTn = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h123; host_wdata = 8'h5A;
        qC2 = 10'd40; qC1 = 11'd300; disp_addr = 11'h400;
        repeat (3) step();
        n_cmp += 5;
        if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", host_ack); end
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", ram_we); end
        if (ram_addr !== 11'd17) begin n_fail++; $display("FAIL rst_addr got %0d want 17", ram_addr); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", host_rdata); end
        RSTn = 1'b1; host_req = 1'b0;
        step();
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h7FF;
        repeat (8) begin
            step();
            if (busy !== 1'b0 || host_ack !== 1'b0) stuck++;
            if (ram_addr !== disp_addr) bad_mux++;
        end
        n_cmp += 2;
        if (stuck != 0) begin n_fail++; $display("FAIL rst_win_hold got %0d busy cycles want 0", stuck); end
        if (bad_mux != 0) begin n_fail++; $display("FAIL rst_win_mux got %0d bad cycles want 0", bad_mux); end
        qC2 = 10'd5;
        while (host_ack !== 1'b1 && lat < 10) begin step(); lat++; end
        n_cmp += 2;
        if (lat != 4) begin n_fail++; $display("FAIL rst_release_lat got %0d want 4", lat); end
        if (host_rdata !== ref_mem[11'h7FF]) begin n_fail++; $display("FAIL rst_release_rd got %h want %h", host_rdata, ref_mem[11'h7FF]); end
        host_req = 1'b0;
        step();
    endtask

    task automatic test_write_blank;
        int lat, w0 = we_cnt;
        logic [7:0] rd;
        qC2 = 10'd5; qC1 = 11'd100;
        host_txn(1'b1, 11'h010, 8'hA5, lat, rd);
        n_cmp += 5;
        if (lat != 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
        if (we_cnt - w0 != 1) begin n_fail++; $display("FAIL wr_pulses got %0d want 1", we_cnt - w0); end
        if (last_wa !== 11'h010) begin n_fail++; $display("FAIL wr_addr got %h want 010", last_wa); end
        if (last_wd !== 8'hA5) begin n_fail++; $display("FAIL wr_data got %h want a5", last_wd); end
        if (host_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width got ack=%b busy=%b want 0 0", host_ack, busy); end
    endtask

    task automatic test_read_blank;
        int lat, w0 = we_cnt;
        logic [7:0] rd;
        qC2 = 10'd5; qC1 = 11'd100;
        host_txn(1'b0, 11'h010, 8'h00, lat, rd);
        n_cmp += 3;
        if (lat != 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", lat); end
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h want a5", rd); end
        if (we_cnt != w0) begin n_fail++; $display("FAIL rd_no_write got %0d pulses want 0", we_cnt - w0); end
    endtask

    task automatic test_contention;
        int iq, aq, ae, de, wc, ewc = 0, ei = exp_issue(40, 250);
        logic [7:0] rd, er = ref_mem[11'h010];
        for (int c = 241; c <= 370; c++) if (win(c - 1, 40)) ewc++;
        run_line(40, 240, 370, 250, 1'b0, 11'h010, 8'h00, iq, aq, rd, ae, de, wc);
        n_cmp += 6;
        if (iq != ei) begin n_fail++; $display("FAIL cont_issue got qC1=%0d want %0d", iq, ei); end
        if (aq != ei + 2) begin n_fail++; $display("FAIL cont_ack got qC1=%0d want %0d", aq, ei + 2); end
        if (rd !== er) begin n_fail++; $display("FAIL cont_rd got %h want %h", rd, er); end
        if (ae != 0) begin n_fail++; $display("FAIL cont_disp_addr got %0d bad want 0", ae); end
        if (de != 0) begin n_fail++; $display("FAIL cont_disp_data got %0d bad want 0", de); end
        if (wc != ewc) begin n_fail++; $display("FAIL cont_win_cycles got %0d want %0d", wc, ewc); end
    endtask

    task automatic test_window_edge;
        int iq, aq, ae, de, wc, ei = exp_issue(40, 212);
        logic [7:0] rd, er = ref_mem[11'h010];
        run_line(40, 205, 230, 212, 1'b0, 11'h010, 8'h00, iq, aq, rd, ae, de, wc);
        n_cmp += 5;
        if (aq != ei + 2) begin n_fail++; $display("FAIL edge_ack got qC1=%0d want %0d", aq, ei + 2); end
        if (aq >= 217) begin n_fail++; $display("FAIL edge_before_fetch got qC1=%0d want <217", aq); end
        if (rd !== er) begin n_fail++; $display("FAIL edge_rd got %h want %h", rd, er); end
        if (ae != 0) begin n_fail++; $display("FAIL edge_disp_addr got %0d bad want 0", ae); end
        if (de != 0) begin n_fail++; $display("FAIL edge_disp_data got %0d bad want 0", de); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [16];
        logic [7:0] rd;
        int idx = 0, n_ack = 0, last = -100, min_gap = 1000, w0 = we_cnt, lat;
        bit adv = 0;
        foreach (vals[i]) vals[i] = 8'($urandom);
        qC2 = 10'd5; qC1 = 11'd50;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'd0; host_wdata = vals[0];
        for (int cyc = 0; cyc < 200 && n_ack < 16; cyc++) begin
            step();
            if (adv) begin idx++; host_addr = 11'(idx); host_wdata = vals[idx]; adv = 0; end
            if (host_ack === 1'b1) begin
                if (n_ack > 0 && cyc - last < min_gap) min_gap = cyc - last;
                last = cyc; ref_mem[idx] = vals[idx]; n_ack++; adv = 1;
            end
        end
        host_req = 1'b0;
        step();
        n_cmp += 3;
        if (n_ack != 16) begin n_fail++; $display("FAIL b2b_acks got %0d want 16", n_ack); end
        if (min_gap != 3) begin n_fail++; $display("FAIL b2b_min_gap got %0d want 3", min_gap); end
        if (we_cnt - w0 != 16) begin n_fail++; $display("FAIL b2b_we_pulses got %0d want 16", we_cnt - w0); end
        for (int i = 0; i < 16; i++) begin
            host_txn(1'b0, 11'(i), 8'h00, lat, rd);
            n_cmp++;
            if (rd !== vals[i] || lat != 3) begin n_fail++; $display("FAIL b2b_readback[%0d] got %h lat %0d want %h lat 3", i, rd, lat, vals[i]); end
        end
    endtask

    task automatic test_random_blank;
        int lat;
        logic [7:0] rd, er;
        for (int i = 0; i < 24; i++) begin
            bit we = 1'($urandom);
            logic [10:0] a = 11'($urandom_range(0, 63));
            logic [7:0] d = 8'($urandom);
            qC2 = 10'($urandom_range(0, 27)); qC1 = 11'($urandom);
            er = ref_mem[a];
            host_txn(we, a, d, lat, rd);
            n_cmp++;
            if (lat != (we ? 2 : 3) || (!we && rd !== er)) begin
                n_fail++; $display("FAIL rnd_blank[%0d] got lat %0d rd %h want lat %0d rd %h", i, lat, rd, we ? 2 : 3, er);
            end
        end
    endtask

    task automatic test_random_lines;
        int rows [6];
        rows = '{27, 28, 155, 156, 0, 0};
        rows[4] = $urandom_range(29, 154);
        rows[5] = $urandom_range(157, 600);
        foreach (rows[k]) begin
            int iq, aq, ae, de, wc, req_at = $urandom_range(215, 345), ei;
            bit we = 1'($urandom);
            logic [10:0] a = 11'($urandom);
            logic [7:0] d = 8'($urandom), rd, er;
            er = ref_mem[a];
            ei = exp_issue(rows[k], req_at);
            run_line(rows[k], 200, 370, req_at, we, a, d, iq, aq, rd, ae, de, wc);
            n_cmp += 3;
            if (iq != ei || aq != ei + (we ? 1 : 2)) begin
                n_fail++; $display("FAIL line[q2=%0d] got issue %0d ack %0d want %0d %0d", rows[k], iq, aq, ei, ei + (we ? 1 : 2));
            end
            if (!we && rd !== er) begin n_fail++; $display("FAIL line_rd[q2=%0d] got %h want %h", rows[k], rd, er); end
            if (ae != 0 || de != 0) begin n_fail++; $display("FAIL line_disp[q2=%0d] got %0d/%0d bad want 0/0", rows[k], ae, de); end
        end
    endtask

    task automatic test_reset_abort;
        int acks = 0;
        qC2 = 10'd5; qC1 = 11'd20;
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h020;
        repeat (2) step();
        RSTn = 1'b0;
        #1;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        host_req = 1'b0;
        step();
        RSTn = 1'b1;
        repeat (5) begin step(); if (host_ack === 1'b1) acks++; end
        if (acks != 0) begin n_fail++; $display("FAIL abort_ack got %0d want 0", acks); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = 8'($urandom);
            mem[i] <= ref_mem[i];
        end
        test_reset();
        test_write_blank();
        test_read_blank();
        test_contention();
        test_window_edge();
        test_back_to_back();
        test_random_blank();
        test_random_lines();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
